// File: rtl/rip_mem_pkg.sv
// Shared types and defaults for the IF/MA single-port memory arbiter.
package rip_mem_pkg;

  typedef enum logic {OWN_IF = 1'b0, OWN_MA = 1'b1} owner_e;

  typedef enum logic {ST_NORMAL = 1'b0, ST_IF_FORCE = 1'b1} arb_state_e;

  typedef struct packed {
    logic   vld;
    owner_e owner;
    logic   wr;
  } resp_ent_t;

  localparam int unsigned DEF_MEM_LAT    = 1;
  localparam int unsigned DEF_STARVE_MAX = 4;

endpackage

// File: rtl/rip_mem_resp_tracker.sv
// MEM_LAT-deep shift register tagging each memory access with its owner and
// write flag so the response can be steered back when the data arrives.
module rip_mem_resp_tracker
  import rip_mem_pkg::*;
#(
  parameter int unsigned MEM_LAT = DEF_MEM_LAT
) (
  input  logic   clk_i,
  input  logic   rst_ni,
  input  logic   push_i,
  input  owner_e owner_i,
  input  logic   wr_i,
  input  logic   flush_i,
  output logic   vld_o,
  output owner_e owner_o,
  output logic   wr_o
);

  resp_ent_t [MEM_LAT-1:0] pipe_q;

  // Flush kills IF entries as they advance; the entry entering this cycle is
  // the post-redirect fetch and survives.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pipe_q <= '0;
    end else begin
      pipe_q[0] <= '{vld: push_i, owner: owner_i, wr: wr_i};
      for (int i = 1; i < int'(MEM_LAT); i++) begin
        pipe_q[i] <= '{vld:   pipe_q[i-1].vld & ~(flush_i & (pipe_q[i-1].owner == OWN_IF)),
                       owner: pipe_q[i-1].owner,
                       wr:    pipe_q[i-1].wr};
      end
    end
  end

  assign vld_o   = pipe_q[MEM_LAT-1].vld;
  assign owner_o = pipe_q[MEM_LAT-1].owner;
  assign wr_o    = pipe_q[MEM_LAT-1].wr;

endmodule

// File: rtl/rip_mem_arbiter.sv
// Arbitrates instruction fetch (IF) and data (MA) onto one memory port, with
// starvation protection for IF and owner-steered read responses.
module rip_mem_arbiter
  import rip_mem_pkg::*;
#(
  parameter int unsigned MEM_LAT    = DEF_MEM_LAT,
  parameter int unsigned STARVE_MAX = DEF_STARVE_MAX
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  input  logic        if_flush,
  output logic        if_gnt,
  output logic        if_rvalid,
  output logic [31:0] if_rdata,
  input  logic        ma_req,
  input  logic [3:0]  ma_we,
  input  logic [31:0] ma_addr,
  input  logic [31:0] ma_wdata,
  output logic        ma_gnt,
  output logic        ma_rvalid,
  output logic [31:0] ma_rdata,
  output logic        mem_en,
  output logic [3:0]  mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  localparam int unsigned CNT_W = $clog2(STARVE_MAX + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_MAX);

  arb_state_e       state_q, state_d;
  logic [CNT_W-1:0] starve_cnt_q, starve_cnt_d;
  logic             if_win, ma_win;
  logic             rsp_vld, rsp_wr;
  owner_e           rsp_own;

  // Grants are gated by reset so nothing reaches memory while RST_N is low.
  always_comb begin
    if_win = RST_N & if_req & (~ma_req | (state_q == ST_IF_FORCE));
    ma_win = RST_N & ma_req & ~if_win;
  end

  always_comb begin
    starve_cnt_d = starve_cnt_q;
    if (!if_req || if_win)          starve_cnt_d = '0;
    else if (starve_cnt_q < CNT_MAX) starve_cnt_d = starve_cnt_q + 1'b1;

    // Switching on the next count lets IF win the very cycle after the
    // STARVE_MAX-th denial.
    state_d = state_q;
    if (state_q == ST_NORMAL) begin
      if (starve_cnt_d == CNT_MAX) state_d = ST_IF_FORCE;
    end else if (if_win) begin
      state_d = ST_NORMAL;
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q      <= ST_NORMAL;
      starve_cnt_q <= '0;
    end else begin
      state_q      <= state_d;
      starve_cnt_q <= starve_cnt_d;
    end
  end

  assign if_gnt    = if_win;
  assign ma_gnt    = ma_win;
  assign mem_en    = if_win | ma_win;
  assign mem_we    = ma_win ? ma_we : 4'h0;
  assign mem_addr  = if_win ? if_addr : (ma_win ? ma_addr : 32'h0);
  assign mem_wdata = ma_win ? ma_wdata : 32'h0;

  rip_mem_resp_tracker #(.MEM_LAT(MEM_LAT)) u_trk (
    .clk_i   (CLK),
    .rst_ni  (RST_N),
    .push_i  (if_win | ma_win),
    .owner_i (ma_win ? OWN_MA : OWN_IF),
    .wr_i    (ma_win & (ma_we != 4'h0)),
    .flush_i (if_flush),
    .vld_o   (rsp_vld),
    .owner_o (rsp_own),
    .wr_o    (rsp_wr)
  );

  assign if_rvalid = rsp_vld & (rsp_own == OWN_IF);
  assign ma_rvalid = rsp_vld & (rsp_own == OWN_MA);
  assign if_rdata  = if_rvalid ? mem_rdata : 32'h0;
  assign ma_rdata  = (ma_rvalid & ~rsp_wr) ? mem_rdata : 32'h0;

endmodule

// File: tb/tb_rip_mem_arbiter.sv
// Scoreboard bench: three arbiters (MEM_LAT 1..3) share one stimulus stream;
// grants are checked at issue, responses popped by per-instance monitors.
module tb_rip_mem_arbiter;
  import rip_mem_pkg::*;

  localparam int NI = 3;

  typedef struct {
    owner_e      own;
    logic [31:0] data;
    int          due;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic        if_req, if_flush, ma_req;
  logic [31:0] if_addr, ma_addr, ma_wdata;
  logic [3:0]  ma_we;

  logic        if_gnt_w [NI], if_rvalid_w [NI], ma_gnt_w [NI], ma_rvalid_w [NI], mem_en_w [NI];
  logic [31:0] if_rdata_w [NI], ma_rdata_w [NI], mem_addr_w [NI], mem_wdata_w [NI], mem_rdata_w [NI];
  logic [3:0]  mem_we_w [NI];

  exp_t sbq [NI][$];
  int n_tests = 0;
  int n_fail  = 0;

  function automatic logic [31:0] mem_fn(input logic [31:0] a);
    return (a == 32'h8000) ? 32'h0000_0013 : ((a ^ 32'h5A5A_0000) + 32'd7);
  endfunction

  for (genvar k = 0; k < NI; k++) begin : g_dut
    logic [31:0] apipe [4];
    logic        rpipe [4];
    exp_t        e;
    owner_e      got_own;
    logic [31:0] got_data;

    rip_mem_arbiter #(.MEM_LAT(k + 1), .STARVE_MAX(4)) u_dut (
      .CLK(clk), .RST_N(rst_n),
      .if_req(if_req), .if_addr(if_addr), .if_flush(if_flush),
      .if_gnt(if_gnt_w[k]), .if_rvalid(if_rvalid_w[k]), .if_rdata(if_rdata_w[k]),
      .ma_req(ma_req), .ma_we(ma_we), .ma_addr(ma_addr), .ma_wdata(ma_wdata),
      .ma_gnt(ma_gnt_w[k]), .ma_rvalid(ma_rvalid_w[k]), .ma_rdata(ma_rdata_w[k]),
      .mem_en(mem_en_w[k]), .mem_we(mem_we_w[k]), .mem_addr(mem_addr_w[k]),
      .mem_wdata(mem_wdata_w[k]), .mem_rdata(mem_rdata_w[k])
    );

    // Memory model: read data appears k+1 cycles after the enable; garbage otherwise.
    always @(posedge clk) begin
      apipe[0] <= mem_addr_w[k];
      rpipe[0] <= mem_en_w[k] && (mem_we_w[k] == 4'h0);
      for (int i = 1; i < 4; i++) begin
        apipe[i] <= apipe[i-1];
        rpipe[i] <= rpipe[i-1];
      end
    end
    assign mem_rdata_w[k] = rpipe[k] ? mem_fn(apipe[k]) : 32'hBAD0_0000;

    always @(negedge clk) begin
      if (!rst_n) begin
        n_tests++;
        if (if_gnt_w[k] || ma_gnt_w[k] || if_rvalid_w[k] || ma_rvalid_w[k] || mem_en_w[k] ||
            if_rdata_w[k] != 0 || ma_rdata_w[k] != 0 || mem_we_w[k] != 0 ||
            mem_addr_w[k] != 0 || mem_wdata_w[k] != 0) begin
          n_fail++;
          $display("FAIL reset_outputs lat=%0d cyc=%0d: got gnt=%b/%b rv=%b/%b en=%b we=%h addr=%h, want all 0",
                   k + 1, cyc, if_gnt_w[k], ma_gnt_w[k], if_rvalid_w[k], ma_rvalid_w[k],
                   mem_en_w[k], mem_we_w[k], mem_addr_w[k]);
        end
      end else begin
        if (sbq[k].size() > 0 && sbq[k][0].due < cyc) begin
          n_tests++; n_fail++;
          $display("FAIL missing_resp lat=%0d cyc=%0d: got nothing, want own=%0d data=%h at cyc %0d",
                   k + 1, cyc, sbq[k][0].own, sbq[k][0].data, sbq[k][0].due);
          e = sbq[k].pop_front();
        end
        if (if_rvalid_w[k] || ma_rvalid_w[k]) begin
          n_tests++;
          got_own  = ma_rvalid_w[k] ? OWN_MA : OWN_IF;
          got_data = ma_rvalid_w[k] ? ma_rdata_w[k] : if_rdata_w[k];
          if (if_rvalid_w[k] && ma_rvalid_w[k]) begin
            n_fail++;
            $display("FAIL dual_rvalid lat=%0d cyc=%0d: got both rvalid, want one", k + 1, cyc);
          end else if (sbq[k].size() == 0) begin
            n_fail++;
            $display("FAIL unexpected_resp lat=%0d cyc=%0d: got own=%0d data=%h, want none",
                     k + 1, cyc, got_own, got_data);
          end else begin
            e = sbq[k].pop_front();
            if (e.own != got_own || e.data != got_data || e.due != cyc) begin
              n_fail++;
              $display("FAIL resp lat=%0d cyc=%0d: got own=%0d data=%h, want own=%0d data=%h due=%0d",
                       k + 1, cyc, got_own, got_data, e.own, e.data, e.due);
            end
          end
        end
        n_tests++;
        if ((!if_rvalid_w[k] && if_rdata_w[k] != 0) || (!ma_rvalid_w[k] && ma_rdata_w[k] != 0)) begin
          n_fail++;
          $display("FAIL idle_rdata lat=%0d cyc=%0d: got if_rdata=%h ma_rdata=%h, want 0 when not valid",
                   k + 1, cyc, if_rdata_w[k], ma_rdata_w[k]);
        end
      end
    end
  end

  task automatic step(input logic ir, input logic [31:0] ia, input logic fl,
                      input logic mr, input logic [3:0] mw, input logic [31:0] maddr,
                      input logic [31:0] wd, input logic eif, input logic ema, input string nm);
    logic [31:0] eaddr, ewd;
    logic [3:0]  ewe;
    exp_t        keep[$];
    if_req = ir; if_addr = ia; if_flush = fl;
    ma_req = mr; ma_we = mw; ma_addr = maddr; ma_wdata = wd;
    eaddr = eif ? ia : (ema ? maddr : 32'h0);
    ewe   = ema ? mw : 4'h0;
    ewd   = ema ? wd : 32'h0;
    @(negedge clk);
    for (int k = 0; k < NI; k++) begin
      n_tests++;
      if (if_gnt_w[k] != eif || ma_gnt_w[k] != ema || mem_en_w[k] != (eif | ema) ||
          mem_we_w[k] != ewe || mem_addr_w[k] != eaddr || mem_wdata_w[k] != ewd) begin
        n_fail++;
        $display("FAIL %s lat=%0d cyc=%0d: got gnt=%b/%b en=%b we=%h addr=%h wd=%h, want gnt=%b/%b en=%b we=%h addr=%h wd=%h",
                 nm, k + 1, cyc, if_gnt_w[k], ma_gnt_w[k], mem_en_w[k], mem_we_w[k], mem_addr_w[k],
                 mem_wdata_w[k], eif, ema, eif | ema, ewe, eaddr, ewd);
      end
      // A flush drops IF responses not yet delivered by this cycle.
      if (fl) begin
        keep = {};
        for (int j = 0; j < sbq[k].size(); j++)
          if (!(sbq[k][j].own == OWN_IF && sbq[k][j].due > cyc)) keep.push_back(sbq[k][j]);
        sbq[k] = keep;
      end
      if (eif) sbq[k].push_back('{OWN_IF, mem_fn(ia), cyc + k + 1});
      if (ema) sbq[k].push_back('{OWN_MA, (mw != 4'h0) ? 32'h0 : mem_fn(maddr), cyc + k + 1});
    end
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0, 0, 0, "idle");
  endtask

  task automatic both(input logic [31:0] ia, input logic [31:0] maddr, input logic eif, input string nm);
    step(1, ia, 0, 1, 4'h0, maddr, 32'h0, eif, ~eif, nm);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got no finish by 100us, want completion");
    $fatal(1, "timeout");
  end

  initial begin
    // Requests held high during reset: nothing may leak out.
    if_req = 1; if_addr = 32'h44; if_flush = 0;
    ma_req = 1; ma_we = 4'hF; ma_addr = 32'h88; ma_wdata = 32'hFFFF_FFFF;
    repeat (2) @(posedge clk);
    #1;
    if_req = 0; ma_req = 0; ma_we = 0; rst_n = 1;
    idle(1);

    step(1, 32'h8000, 0, 0, 4'h0, 32'h0, 32'h0, 1, 0, "if_only");
    idle(3);

    step(1, 32'h8004, 0, 1, 4'hF, 32'h100, 32'hDEADBEEF, 0, 1, "conflict_wr");
    idle(3);

    step(0, 0, 0, 1, 4'h0, 32'h200, 32'h0, 0, 1, "b2b_ma_rd");
    step(1, 32'h300, 0, 0, 4'h0, 32'h0, 32'h0, 1, 0, "b2b_if");
    step(0, 0, 0, 1, 4'h3, 32'h204, 32'h1234_5678, 0, 1, "b2b_ma_wr");
    step(0, 0, 0, 1, 4'h0, 32'h208, 32'h0, 0, 1, "b2b_ma_rd2");
    idle(4);

    for (int i = 0; i < 6; i++) both(32'h1000, 32'h400 + 32'(4 * i), i == 4, "starve");
    idle(4);

    // A cycle without if_req restarts the starvation count.
    both(32'h1100, 32'h500, 0, "starve_clr_a");
    both(32'h1100, 32'h504, 0, "starve_clr_b");
    step(0, 0, 0, 1, 4'h0, 32'h508, 32'h0, 0, 1, "starve_clr_ma_only");
    for (int i = 0; i < 5; i++) both(32'h1100, 32'h50C + 32'(4 * i), i == 4, "starve_clr_run");
    idle(4);

    // In IF_FORCE a lone MA still wins and the forced state persists.
    for (int i = 0; i < 4; i++) both(32'h1200, 32'h600 + 32'(4 * i), 0, "force_prep");
    step(0, 0, 0, 1, 4'h0, 32'h610, 32'h0, 0, 1, "force_lone_ma");
    both(32'h1200, 32'h614, 1, "force_if_wins");
    both(32'h1204, 32'h618, 0, "force_back_normal");
    idle(4);

    step(1, 32'h2000, 0, 0, 4'h0, 32'h0, 32'h0, 1, 0, "flush_if0");
    step(1, 32'h2004, 0, 0, 4'h0, 32'h0, 32'h0, 1, 0, "flush_if1");
    step(1, 32'h2008, 1, 0, 4'h0, 32'h0, 32'h0, 1, 0, "flush_same_cycle_if");
    idle(5);

    step(1, 32'h2100, 0, 0, 4'h0, 32'h0, 32'h0, 1, 0, "flush_ma_if");
    step(0, 0, 0, 1, 4'h0, 32'h2200, 32'h0, 0, 1, "flush_ma_rd");
    step(0, 0, 1, 0, 4'h0, 32'h0, 32'h0, 0, 0, "flush_idle");
    idle(5);

    // Mid-transaction reset after partial starvation.
    for (int i = 0; i < 3; i++) both(32'h3000, 32'h700 + 32'(4 * i), 0, "pre_reset");
    if_req = 1; ma_req = 1; rst_n = 0;
    for (int k = 0; k < NI; k++) sbq[k].delete();
    @(posedge clk); #1;
    rst_n = 1;
    for (int i = 0; i < 5; i++) both(32'h3100, 32'h800 + 32'(4 * i), i == 4, "post_reset");
    idle(5);

    for (int k = 0; k < NI; k++) begin
      n_tests++;
      if (sbq[k].size() != 0) begin
        n_fail++;
        $display("FAIL leftover lat=%0d: got %0d pending responses, want 0", k + 1, sbq[k].size());
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
